// File: rtl/ram_port_arb.sv
// Two-client read and two-client write arbiter in front of a simple dual-port RAM.
// Each side is round-robin; write-to-read bypass covers the RAM's lack of collision handling.
module ram_port_arb #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 rd0_req,
  input  logic [ADDR_BITS-1:0] rd0_addr,
  output logic                 rd0_gnt,
  output logic                 rd0_valid,
  output logic [WIDTH-1:0]     rd0_data,

  input  logic                 rd1_req,
  input  logic [ADDR_BITS-1:0] rd1_addr,
  output logic                 rd1_gnt,
  output logic                 rd1_valid,
  output logic [WIDTH-1:0]     rd1_data,

  input  logic                 wr0_req,
  input  logic [ADDR_BITS-1:0] wr0_addr,
  input  logic [WIDTH-1:0]     wr0_data,
  output logic                 wr0_gnt,

  input  logic                 wr1_req,
  input  logic [ADDR_BITS-1:0] wr1_addr,
  input  logic [WIDTH-1:0]     wr1_data,
  output logic                 wr1_gnt,

  output logic [ADDR_BITS-1:0] ram_wrad,
  output logic                 ram_we,
  output logic [WIDTH-1:0]     ram_d,
  output logic [ADDR_BITS-1:0] ram_rdad,
  input  logic [WIDTH-1:0]     ram_q
);

  logic             last_rd;
  logic             last_wr;
  logic [1:0]       rd_vld_q;
  logic             byp_hit_q;
  logic [WIDTH-1:0] byp_data_q;
  logic [WIDTH-1:0] rd_word;

  // Under contention the client that did not win last time is granted.
  always_comb begin
    rd0_gnt = ~reset & rd0_req & (~rd1_req |  last_rd);
    rd1_gnt = ~reset & rd1_req & (~rd0_req | ~last_rd);
    wr0_gnt = ~reset & wr0_req & (~wr1_req |  last_wr);
    wr1_gnt = ~reset & wr1_req & (~wr0_req | ~last_wr);
  end

  always_comb begin
    ram_rdad = '0;
    if (rd0_gnt)      ram_rdad = rd0_addr;
    else if (rd1_gnt) ram_rdad = rd1_addr;

    ram_we   = wr0_gnt | wr1_gnt;
    ram_wrad = '0;
    ram_d    = '0;
    if (wr0_gnt) begin
      ram_wrad = wr0_addr;
      ram_d    = wr0_data;
    end else if (wr1_gnt) begin
      ram_wrad = wr1_addr;
      ram_d    = wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd    <= 1'b1;
      last_wr    <= 1'b1;
      rd_vld_q   <= '0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      if (rd0_gnt | rd1_gnt) last_rd <= rd1_gnt;
      if (wr0_gnt | wr1_gnt) last_wr <= wr1_gnt;
      rd_vld_q   <= {rd1_gnt, rd0_gnt};
      // The RAM returns pre-write data on a same-cycle collision, so capture the write instead.
      byp_hit_q  <= ram_we & (rd0_gnt | rd1_gnt) & (ram_wrad == ram_rdad);
      byp_data_q <= ram_d;
    end
  end

  // Valid is masked by reset so a read accepted just before reset never pulses.
  always_comb begin
    rd_word   = byp_hit_q ? byp_data_q : ram_q;
    rd0_valid = rd_vld_q[0] & ~reset;
    rd1_valid = rd_vld_q[1] & ~reset;
    rd0_data  = rd0_valid ? rd_word : '0;
    rd1_data  = rd1_valid ? rd_word : '0;
  end

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed self-checking bench for ram_port_arb with a behavioural registered-read RAM.
module tb_ram_port_arb;

  localparam int WIDTH     = 64;
  localparam int DEPTH     = 32;
  localparam int ADDR_BITS = 5;
  localparam logic [WIDTH-1:0] PAT = 64'hD0D0_0000_0000_0000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 rd0_req = 1'b0, rd1_req = 1'b0, wr0_req = 1'b0, wr1_req = 1'b0;
  logic [ADDR_BITS-1:0] rd0_addr = '0, rd1_addr = '0, wr0_addr = '0, wr1_addr = '0;
  logic [WIDTH-1:0]     wr0_data = '0, wr1_data = '0;
  logic                 rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt;
  logic                 rd0_valid, rd1_valid;
  logic [WIDTH-1:0]     rd0_data, rd1_data;
  logic [ADDR_BITS-1:0] ram_wrad, ram_rdad;
  logic                 ram_we;
  logic [WIDTH-1:0]     ram_d;
  logic [WIDTH-1:0]     ram_q = '0;
  logic [WIDTH-1:0]     mem [DEPTH];

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wrad] <= ram_d;
    ram_q <= mem[ram_rdad];
  end

  ram_port_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .ram_wrad(ram_wrad), .ram_we(ram_we), .ram_d(ram_d), .ram_rdad(ram_rdad), .ram_q(ram_q)
  );

  task automatic clr_reqs();
    rd0_req = 1'b0; rd1_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; clr_reqs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      clr_reqs();
      wr0_req = 1'b1; wr0_addr = ADDR_BITS'(i);
      wr0_data = (i == 7) ? 64'hAAAA : (PAT | WIDTH'(i));
    end
    @(posedge clk); #1 clr_reqs();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rd0_req = 1'b1; rd1_req = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1;
    rd0_addr = 5'd9; rd1_addr = 5'd10; wr0_addr = 5'd11; wr1_addr = 5'd12;
    wr0_data = 64'h55; wr1_data = 64'h66;
    repeat (2) begin
      @(negedge clk);
      vec++;
      if ({rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt} !== 4'b0000) begin
        errs++; $display("FAIL reset_gnts: got %b expected 0000", {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt});
      end
      vec++;
      if ({rd0_valid, rd1_valid, ram_we} !== 3'b000) begin
        errs++; $display("FAIL reset_valid_we: got %b expected 000", {rd0_valid, rd1_valid, ram_we});
      end
      vec++;
      if (ram_rdad !== '0 || ram_wrad !== '0 || ram_d !== '0) begin
        errs++; $display("FAIL reset_ram_bus: got rdad=%0d wrad=%0d d=%h expected zeros", ram_rdad, ram_wrad, ram_d);
      end
      vec++;
      if (rd0_data !== '0 || rd1_data !== '0) begin
        errs++; $display("FAIL reset_rdata: got %h/%h expected 0/0", rd0_data, rd1_data);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; clr_reqs();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 clr_reqs();
      @(negedge clk);
      vec++;
      if ({rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt, rd0_valid, rd1_valid, ram_we} !== 7'b0 ||
          ram_rdad !== '0 || ram_wrad !== '0) begin
        errs++; $display("FAIL idle_%0d: got flags=%b rdad=%0d wrad=%0d expected all 0", i,
                         {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt, rd0_valid, rd1_valid, ram_we}, ram_rdad, ram_wrad);
      end
    end
  endtask

  task automatic test_contested_reads();
    logic [1:0] eg, ev;
    logic [WIDTH-1:0] ed0, ed1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rd0_req = (i < 4); rd1_req = (i < 4); rd0_addr = 5'd3; rd1_addr = 5'd5;
      @(negedge clk);
      eg = (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
      ev = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b10 : 2'b01);
      ed0 = ev[1] ? 64'hD0D0_0000_0000_0003 : '0;
      ed1 = ev[0] ? 64'hD0D0_0000_0000_0005 : '0;
      vec++;
      if ({rd0_gnt, rd1_gnt} !== eg) begin
        errs++; $display("FAIL cread_gnt_%0d: got %b expected %b", i, {rd0_gnt, rd1_gnt}, eg);
      end
      vec++;
      if ({rd0_valid, rd1_valid} !== ev || rd0_data !== ed0 || rd1_data !== ed1) begin
        errs++; $display("FAIL cread_resp_%0d: got v=%b d0=%h d1=%h expected v=%b d0=%h d1=%h",
                         i, {rd0_valid, rd1_valid}, rd0_data, rd1_data, ev, ed0, ed1);
      end
      if (i < 4) begin
        vec++;
        if (ram_rdad !== (eg[1] ? 5'd3 : 5'd5)) begin
          errs++; $display("FAIL cread_rdad_%0d: got %0d expected %0d", i, ram_rdad, eg[1] ? 3 : 5);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ed;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      clr_reqs(); rd1_req = (i < 5); rd1_addr = ADDR_BITS'(i);
      @(negedge clk);
      vec++;
      if (rd1_gnt !== (i < 5) || rd0_gnt !== 1'b0) begin
        errs++; $display("FAIL stream_gnt_%0d: got rd1=%b rd0=%b expected rd1=%b rd0=0", i, rd1_gnt, rd0_gnt, i < 5);
      end
      ed = (i == 0) ? '0 : (PAT | WIDTH'(i - 1));
      vec++;
      if (rd1_valid !== (i > 0) || rd1_data !== ed || rd0_valid !== 1'b0) begin
        errs++; $display("FAIL stream_resp_%0d: got v=%b d=%h expected v=%b d=%h", i, rd1_valid, rd1_data, i > 0, ed);
      end
    end
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    clr_reqs(); rd0_req = 1'b1; rd0_addr = 5'd7;
    @(posedge clk); #1;
    clr_reqs();
    wr0_req = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h1234;
    rd1_req = 1'b1; rd1_addr = 5'd7;
    @(negedge clk);
    vec++;
    if (rd0_valid !== 1'b1 || rd0_data !== 64'hAAAA) begin
      errs++; $display("FAIL byp_old_word: got v=%b d=%h expected v=1 d=aaaa", rd0_valid, rd0_data);
    end
    vec++;
    if ({wr0_gnt, rd1_gnt, ram_we} !== 3'b111 || ram_wrad !== 5'd7 || ram_d !== 64'h1234 || ram_rdad !== 5'd7) begin
      errs++; $display("FAIL byp_ports: got g=%b wrad=%0d d=%h rdad=%0d expected g=111 wrad=7 d=1234 rdad=7",
                       {wr0_gnt, rd1_gnt, ram_we}, ram_wrad, ram_d, ram_rdad);
    end
    @(posedge clk); #1;
    clr_reqs(); rd1_req = 1'b1; rd1_addr = 5'd7;
    @(negedge clk);
    vec++;
    if (rd1_valid !== 1'b1 || rd1_data !== 64'h1234 || rd0_valid !== 1'b0 || rd0_data !== '0) begin
      errs++; $display("FAIL byp_hit: got v1=%b d1=%h v0=%b d0=%h expected v1=1 d1=1234 v0=0 d0=0",
                       rd1_valid, rd1_data, rd0_valid, rd0_data);
    end
    @(posedge clk); #1 clr_reqs();
    @(negedge clk);
    vec++;
    if (rd1_valid !== 1'b1 || rd1_data !== 64'h1234) begin
      errs++; $display("FAIL byp_after: got v=%b d=%h expected v=1 d=1234", rd1_valid, rd1_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (rd1_valid !== 1'b0 || rd1_data !== '0) begin
      errs++; $display("FAIL byp_single_pulse: got v=%b d=%h expected v=0 d=0", rd1_valid, rd1_data);
    end
  endtask

  task automatic test_contested_writes();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      clr_reqs();
      wr0_req = 1'b1; wr0_addr = 5'd1; wr0_data = 64'h11;
      wr1_req = 1'b1; wr1_addr = 5'd2; wr1_data = 64'h22;
      @(negedge clk);
      vec++;
      if ({wr0_gnt, wr1_gnt} !== ((i == 0) ? 2'b10 : 2'b01) || ram_we !== 1'b1 ||
          ram_wrad !== ((i == 0) ? 5'd1 : 5'd2) || ram_d !== ((i == 0) ? 64'h11 : 64'h22)) begin
        errs++; $display("FAIL cwrite_%0d: got g=%b we=%b wrad=%0d d=%h expected g=%b we=1 wrad=%0d d=%h",
                         i, {wr0_gnt, wr1_gnt}, ram_we, ram_wrad, ram_d,
                         (i == 0) ? 2'b10 : 2'b01, i + 1, (i == 0) ? 64'h11 : 64'h22);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      clr_reqs(); rd0_req = (i < 2); rd0_addr = ADDR_BITS'(i + 1);
      @(negedge clk);
      if (i > 0) begin
        vec++;
        if (rd0_valid !== 1'b1 || rd0_data !== ((i == 1) ? 64'h11 : 64'h22)) begin
          errs++; $display("FAIL cwrite_readback_%0d: got v=%b d=%h expected v=1 d=%h",
                           i, rd0_valid, rd0_data, (i == 1) ? 64'h11 : 64'h22);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    clr_reqs(); rd0_req = 1'b1; rd0_addr = 5'd4;
    @(negedge clk);
    vec++;
    if (rd0_gnt !== 1'b1) begin
      errs++; $display("FAIL inflight_gnt: got %b expected 1", rd0_gnt);
    end
    @(posedge clk); #1;
    reset = 1'b1; clr_reqs();
    @(negedge clk);
    vec++;
    if (rd0_valid !== 1'b0 || rd0_data !== '0) begin
      errs++; $display("FAIL inflight_dropped: got v=%b d=%h expected v=0 d=0", rd0_valid, rd0_data);
    end
    @(posedge clk); #1;
    rd0_req = 1'b1; rd1_req = 1'b1;
    @(negedge clk);
    vec++;
    if ({rd0_gnt, rd1_gnt, rd0_valid, rd1_valid} !== 4'b0000) begin
      errs++; $display("FAIL inflight_in_reset: got %b expected 0000", {rd0_gnt, rd1_gnt, rd0_valid, rd1_valid});
    end
    @(posedge clk); #1;
    reset = 1'b0; clr_reqs();
    @(negedge clk);
    vec++;
    if ({rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, ram_we} !== 5'b0) begin
      errs++; $display("FAIL inflight_post_idle: got %b expected 00000", {rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, ram_we});
    end
    @(posedge clk); #1;
    rd0_req = 1'b1; rd1_req = 1'b1; rd0_addr = 5'd4; rd1_addr = 5'd6;
    @(negedge clk);
    vec++;
    if ({rd0_gnt, rd1_gnt} !== 2'b10) begin
      errs++; $display("FAIL inflight_first_contest: got %b expected 10", {rd0_gnt, rd1_gnt});
    end
    @(posedge clk); #1 clr_reqs();
    @(negedge clk);
    vec++;
    if (rd0_valid !== 1'b1 || rd0_data !== 64'hD0D0_0000_0000_0004 || rd1_valid !== 1'b0) begin
      errs++; $display("FAIL inflight_resp: got v0=%b d0=%h v1=%b expected v0=1 d0=d0d0000000000004 v1=0",
                       rd0_valid, rd0_data, rd1_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload();
    do_reset();
    test_idle();
    test_contested_reads();
    test_back_to_back();
    test_bypass();
    test_contested_writes();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/ram_port_arb.md
RAM_PORT_ARB -- requirements
Module: ram_port_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 64: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32: number of RAM words.
REQ-003 The block SHALL have parameter ADDR_BITS, default $clog2(DEPTH): address width in bits.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have ports rd0_req / rd1_req, input, 1: read request from client n.
REQ-007 The block SHALL have ports rd0_addr / rd1_addr, input, ADDR_BITS: read address from client n.
REQ-008 The block SHALL have ports rd0_gnt / rd1_gnt, output, 1: combinational grant; a read is accepted in any cycle where req and gnt are both high.
REQ-009 The block SHALL have ports rd0_valid / rd1_valid, output, 1: read response valid for client n.
REQ-010 The block SHALL have ports rd0_data / rd1_data, output, WIDTH: read response data for client n.
REQ-011 The block SHALL have ports wr0_req / wr1_req, input, 1: write request from client n.
REQ-012 The block SHALL have ports wr0_addr / wr1_addr (input, ADDR_BITS) and wr0_data / wr1_data (input, WIDTH): write address and data from client n.
REQ-013 The block SHALL have ports wr0_gnt / wr1_gnt, output, 1: combinational write grant.
REQ-014 The block SHALL have RAM-side ports ram_wrad (output, ADDR_BITS), ram_we (output, 1), ram_d (output, WIDTH), ram_rdad (output, ADDR_BITS) and ram_q (input, WIDTH), connecting to a simple dual-port RAM with a registered read (1-cycle latency) and no read/write collision check.

Function
REQ-015 The block SHALL grant at most one read client and at most one write client per cycle; read and write arbitration are independent.
REQ-016 Read arbitration SHALL be round-robin with a 1-bit last_rd register:
- one requester: that requester is granted;
- both requesting: the client not equal to last_rd is granted.
REQ-017 On every read grant, last_rd SHALL be loaded with the granted index; it SHALL hold when there is no read grant.
REQ-018 Write arbitration SHALL use an identical round-robin scheme with its own register, last_wr.
REQ-019 Grants SHALL depend only on the current req inputs and last_* registers, with no combinational path from any addr or data input.
REQ-020 RAM read port, granted read: ram_rdad SHALL equal the granted client's address. No read granted: ram_rdad SHALL be 0.
REQ-021 RAM write port, granted write: ram_we SHALL be 1, and ram_wrad / ram_d SHALL equal the granted client's address and data. No write granted: ram_we, ram_wrad and ram_d SHALL all be 0.
REQ-022 Read latency SHALL be exactly 1 cycle: a read accepted in cycle N SHALL assert rdX_valid for exactly one cycle, N+1, for the granted client only.
REQ-023 Response data:
- normal case: rdX_data in cycle N+1 SHALL equal ram_q;
- bypass case: if a write was granted in cycle N to the same address as the read, rdX_data SHALL instead equal that cycle-N write data (registered bypass).
REQ-024 When rdX_valid is 0, rdX_data SHALL be 0.
REQ-025 A client SHALL be able to be granted back-to-back every cycle when it is the only requester; when both clients request continuously, grants SHALL alternate every cycle.
REQ-026 A read and a write to the same address granted in cycle N SHALL leave the RAM updated with the new data, and a read granted in N+1 to that address SHALL return the new data with no bypass needed.

Reset
REQ-027 While reset is high, all rdX_gnt, wrX_gnt, rdX_valid and ram_we SHALL be 0, and rdX_data, ram_wrad, ram_d and ram_rdad SHALL be 0.
REQ-028 Reset SHALL set last_rd = 1 and last_wr = 1, so client 0 wins the first contested arbitration.
REQ-029 Reset mid-operation: a read accepted in the cycle before reset was asserted SHALL be dropped, with no valid pulse in any cycle while reset is high. The first cycle after reset deasserts SHALL behave as post-reset idle.

Verification
REQ-030 Contested reads:
- stimulus: after reset, rd0_req = rd1_req = 1 for 4 cycles, rd0_addr = 3, rd1_addr = 5;
- required: grants go rd0, rd1, rd0, rd1; valids follow one cycle later on the matching client with RAM contents of word 3 / word 5.
REQ-031 Read/write bypass:
- stimulus: word 7 holds 0xAAAA; in one cycle, wr0 writes 0x1234 to address 7 while rd1 reads address 7;
- required: next cycle rd1_valid = 1, rd1_data = 0x1234; a read of 7 one cycle later also returns 0x1234.
REQ-032 Contested writes:
- stimulus: wr0 and wr1 both request for 2 cycles, to addresses 1 and 2 with data 0x11 and 0x22;
- required: the wr0 grant comes first, then wr1; subsequent reads return word 1 = 0x11 and word 2 = 0x22.
REQ-033 Reset during an in-flight read:
- stimulus: rd0 is granted in cycle N and reset is asserted in cycle N+1;
- required: rd0_valid = 0 in N+1; the first contested read after reset grants rd0.
REQ-034 Idle:
- stimulus: no requests for 10 cycles;
- required: all grants, valids and ram_we are 0, and ram_rdad = ram_wrad = 0.
REQ-035 Single-requester streaming:
- stimulus: rd1 alone requests for 5 cycles, addresses 0 to 4;
- required: granted every cycle; 5 consecutive valid pulses with data in address order.
